// File: rtl/nios2_oci_dct_capture_pkg.sv
// rtl/nios2_oci_dct_capture_pkg.sv - shared types and width helpers for the DCT capture block
package nios2_oci_dct_capture_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_DONE    = 2'd3
   } dct_state_t;

   // Width of a level counter that must represent 0..depth inclusive
   function automatic int lvl_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/nios2_oci_dct_capture_if.sv
// rtl/nios2_oci_dct_capture_if.sv - valid/ready output stream carrying captured trace frames
interface nios2_oci_dct_capture_if #(
   parameter int DCT_W = 30,
   parameter int CNT_W = 4,
   parameter int SEQ_W = 8
);
   logic             out_valid;
   logic             out_ready;
   logic [DCT_W-1:0] out_data;
   logic [CNT_W-1:0] out_count;
   logic [SEQ_W-1:0] out_seq;

   modport master (output out_valid, out_data, out_count, out_seq, input out_ready);
   modport slave  (input out_valid, out_data, out_count, out_seq, output out_ready);
endinterface

// File: rtl/nios2_oci_dct_capture_fifo.sv
// rtl/nios2_oci_dct_capture_fifo.sv - synchronous FIFO with registered head, full/empty/level
module nios2_oci_dct_capture_fifo
   import nios2_oci_dct_capture_pkg::*;
#(
   parameter int WIDTH = 42,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         head,
   output logic                     empty,
   output logic                     full,
   output logic [lvl_w(DEPTH)-1:0]  level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = lvl_w(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   // Storage array; contents need no reset because the head is masked while empty
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   // Pointers and occupancy; caller only pushes when space exists or a pop frees a slot
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         level <= level + LW'(push) - LW'(pop);
      end
   end

   assign empty = (level == '0);
   assign full  = (level == LW'(DEPTH));
   assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/nios2_oci_dct_capture.sv
// rtl/nios2_oci_dct_capture.sv - DCT trace capture: FSM, sequence tagging, overflow tracking
module nios2_oci_dct_capture
   import nios2_oci_dct_capture_pkg::*;
#(
   parameter int DCT_W = 30,
   parameter int CNT_W = 4,
   parameter int DEPTH = 16,
   parameter int SEQ_W = 8,
   parameter int OVF_W = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     arm,
   input  logic                     dct_valid,
   input  logic [DCT_W-1:0]         dct_buffer,
   input  logic [CNT_W-1:0]         dct_count,
   input  logic                     test_ending,
   input  logic                     test_has_ended,
   nios2_oci_dct_capture_if.master  out_if,
   output logic [lvl_w(DEPTH)-1:0]  fill_level,
   output logic                     overflow,
   output logic [OVF_W-1:0]         overflow_cnt,
   output logic [1:0]               state,
   output logic                     done
);
   localparam int FW = DCT_W + CNT_W + SEQ_W;
   localparam int LW = lvl_w(DEPTH);

   dct_state_t       state_q;
   dct_state_t       state_d;
   logic [SEQ_W-1:0] seq_q;
   logic             accept_req;
   logic             push;
   logic             pop;
   logic             drop;
   logic             drained;
   logic             fifo_empty;
   logic             fifo_full;
   logic [FW-1:0]    head;

   // A full FIFO still takes a frame when the consumer frees a slot this same cycle
   assign pop        = out_if.out_valid && out_if.out_ready;
   assign accept_req = (state_q == ST_CAPTURE) && dct_valid && (dct_count != '0);
   assign push       = accept_req && (!fifo_full || pop);
   assign drop       = accept_req && fifo_full && !pop;
   assign drained    = fifo_empty || ((fill_level == LW'(1)) && pop);

   nios2_oci_dct_capture_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .wdata   ({dct_buffer, dct_count, seq_q}),
      .head    (head),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .level   (fill_level)
   );

   assign out_if.out_valid = !fifo_empty && (state_q != ST_DONE);
   assign {out_if.out_data, out_if.out_count, out_if.out_seq} = head;
   assign state = state_q;

   // State register and registered done flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         done    <= (state_d == ST_DONE);
      end
   end

   // Next-state: only the test_* handshake ends capture; arm merely starts it
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (test_has_ended)               state_d = ST_DONE;
            else if (arm && !test_ending)     state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (test_ending || test_has_ended) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (drained && test_has_ended)    state_d = ST_DONE;
         end
         default: state_d = ST_DONE;
      endcase
   end

   // Sequence tag advances only on frames that actually land in the FIFO
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) seq_q <= '0;
      else if (push) seq_q <= seq_q + 1'b1;
   end

   // Sticky overflow flag and saturating drop counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow     <= 1'b0;
         overflow_cnt <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (overflow_cnt != '1) overflow_cnt <= overflow_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_nios2_oci_dct_capture.sv
// tb/tb_nios2_oci_dct_capture.sv - randomized self-checking bench with queue reference model
module tb_nios2_oci_dct_capture;
   logic        clk;
   logic        reset_n;
   logic        arm;
   logic        dct_valid;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        test_ending;
   logic        test_has_ended;
   logic        out_ready;

   logic [4:0]  fill_a, fill_b;
   logic        ovf_a, ovf_b;
   logic [15:0] ovf_cnt_a, ovf_cnt_b;
   logic [1:0]  state_a, state_b;
   logic        done_a, done_b;

   nios2_oci_dct_capture_if #(.DCT_W(30), .CNT_W(4), .SEQ_W(8)) a_if ();
   nios2_oci_dct_capture_if #(.DCT_W(30), .CNT_W(4), .SEQ_W(2)) b_if ();

   assign a_if.out_ready = out_ready;
   assign b_if.out_ready = out_ready;

   nios2_oci_dct_capture #(.DCT_W(30), .CNT_W(4), .DEPTH(16), .SEQ_W(8), .OVF_W(16)) dut_a (
      .clk(clk), .reset_n(reset_n), .arm(arm), .dct_valid(dct_valid),
      .dct_buffer(dct_buffer), .dct_count(dct_count), .test_ending(test_ending),
      .test_has_ended(test_has_ended), .out_if(a_if), .fill_level(fill_a),
      .overflow(ovf_a), .overflow_cnt(ovf_cnt_a), .state(state_a), .done(done_a));

   nios2_oci_dct_capture #(.DCT_W(30), .CNT_W(4), .DEPTH(16), .SEQ_W(2), .OVF_W(16)) dut_b (
      .clk(clk), .reset_n(reset_n), .arm(arm), .dct_valid(dct_valid),
      .dct_buffer(dct_buffer), .dct_count(dct_count), .test_ending(test_ending),
      .test_has_ended(test_has_ended), .out_if(b_if), .fill_level(fill_b),
      .overflow(ovf_b), .overflow_cnt(ovf_cnt_b), .state(state_b), .done(done_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [29:0] d;
      logic [3:0]  c;
      int          s;
   } frame_t;

   frame_t q[$];
   int     m_state;
   int     m_seq;
   int     m_ovf_cnt;
   bit     m_ovf;
   int     n_checks;
   int     n_pass;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      q.delete();
      m_state   = 0;
      m_seq     = 0;
      m_ovf_cnt = 0;
      m_ovf     = 0;
   endtask

   // Behavioural view: a bounded queue, states as numbers, counters as plain integers
   task automatic model_step();
      int     n0;
      bit     p;
      bit     a;
      frame_t f;
      n0 = q.size();
      p  = (n0 > 0) && (m_state != 3) && out_ready;
      a  = (m_state == 1) && dct_valid && (dct_count != 0);
      if (p) void'(q.pop_front());
      if (a) begin
         if (n0 < 16 || p) begin
            f.d = dct_buffer; f.c = dct_count; f.s = m_seq;
            q.push_back(f);
            m_seq++;
         end else begin
            m_ovf = 1;
            if (m_ovf_cnt < 65535) m_ovf_cnt++;
         end
      end
      case (m_state)
         0: if (test_has_ended) m_state = 3; else if (arm && !test_ending) m_state = 1;
         1: if (test_ending || test_has_ended) m_state = 2;
         2: if (test_has_ended && q.size() == 0) m_state = 3;
         default: m_state = 3;
      endcase
   endtask

   task automatic check_all();
      bit ev;
      ev = (q.size() > 0) && (m_state != 3);
      check("out_valid", a_if.out_valid, ev);
      check("out_valid_w2", b_if.out_valid, ev);
      if (ev) begin
         check("out_data", a_if.out_data, q[0].d);
         check("out_count", a_if.out_count, q[0].c);
         check("out_seq", a_if.out_seq, q[0].s % 256);
         check("out_seq_w2", b_if.out_seq, q[0].s % 4);
      end
      check("fill_level", fill_a, q.size());
      check("fill_level_w2", fill_b, q.size());
      check("overflow", ovf_a, m_ovf);
      check("overflow_cnt", ovf_cnt_a, m_ovf_cnt);
      check("overflow_cnt_w2", ovf_cnt_b, m_ovf_cnt);
      check("state", state_a, m_state);
      check("state_w2", state_b, m_state);
      check("done", done_a, m_state == 3);
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic drive(input bit v, input logic [29:0] d, input logic [3:0] c, input bit r);
      dct_valid = v; dct_buffer = d; dct_count = c; out_ready = r;
   endtask

   task automatic idle_inputs();
      arm = 0; test_ending = 0; test_has_ended = 0;
      drive(0, '0, '0, 0);
   endtask

   // Asynchronous reset pulse placed away from any clock edge
   task automatic do_reset();
      #2 reset_n = 0;
      #1;
      model_reset();
      check("rst_valid", a_if.out_valid, 0);
      check("rst_data", a_if.out_data, 0);
      check("rst_fill", fill_a, 0);
      check("rst_state", state_a, 0);
      check("rst_ovf_cnt", ovf_cnt_a, 0);
      check("rst_done", done_a, 0);
      @(negedge clk);
      idle_inputs();
      reset_n = 1;
      check_all();
   endtask

   initial begin
      n_checks = 0; n_pass = 0;
      reset_n = 0;
      idle_inputs();
      model_reset();
      @(negedge clk);
      check_all();
      reset_n = 1;

      // Fill to 5 then reset mid-stream
      arm = 1; step();
      for (int i = 0; i < 5; i++) begin drive(1, 30'($urandom), 4'($urandom_range(1, 15)), 0); step(); end
      check("fill5", fill_a, 5);
      do_reset();

      // Basic three-frame flow with consumer always ready
      arm = 1; step();
      for (int i = 1; i <= 3; i++) begin drive(1, 30'(i), 4'(i), 1); step(); end
      drive(0, '0, '0, 1); step(); step();

      // Overflow: 20 frames into a stalled FIFO, then a push alongside a pop at full
      do_reset();
      arm = 1; step();
      for (int i = 0; i < 20; i++) begin drive(1, 30'($urandom), 4'($urandom_range(1, 15)), 0); step(); end
      check("ovf_fill16", fill_a, 16);
      check("ovf_flag", ovf_a, 1);
      check("ovf_cnt4", ovf_cnt_a, 4);
      drive(1, 30'($urandom), 4'($urandom_range(1, 15)), 1); step();
      check("fullpop_cnt", ovf_cnt_a, 4);
      check("fullpop_fill", fill_a, 16);
      drive(0, '0, '0, 1);
      for (int i = 0; i < 18; i++) step();

      // Random traffic including zero-count frames and wrap of the narrow tag
      for (int i = 0; i < 400; i++) begin
         arm = 1'($urandom);
         drive(1'($urandom), 30'($urandom),
               ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
               ($urandom_range(0, 2) != 0));
         step();
      end
      test_ending = 1; test_has_ended = 1;
      for (int i = 0; i < 40; i++) begin drive(1, 30'($urandom), 4'($urandom_range(1, 15)), 1'($urandom)); step(); end
      drive(0, '0, '0, 1);
      for (int i = 0; i < 20; i++) step();

      // End protocol: 3 stored, test_ending with a push, drain, then has_ended
      do_reset();
      arm = 1; step();
      for (int i = 0; i < 3; i++) begin drive(1, 30'($urandom), 4'($urandom_range(1, 15)), 0); step(); end
      test_ending = 1; drive(1, 30'($urandom), 4'($urandom_range(1, 15)), 0); step();
      check("end_fill4", fill_a, 4);
      for (int i = 0; i < 6; i++) begin drive(1, 30'($urandom), 4'($urandom_range(1, 15)), 1); step(); end
      test_has_ended = 1; step();
      check("end_done", done_a, 1);
      check("end_state", state_a, 3);
      for (int i = 0; i < 3; i++) step();

      // test_has_ended straight out of IDLE
      do_reset();
      test_has_ended = 1; step();
      check("idle_to_done", state_a, 3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
